// File: rtl/slc3_mem_arbiter.sv
// Two-port SRAM arbiter for SLC-3: CPU datapath vs debug/loader port.
// Round-robin on ties, fixed-wait strobe sequencing, one-cycle ack.
module slc3_mem_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       grant;
  logic       last_grant;
  logic       we_q;
  logic       pick_dbg;
  logic       win_we;

  // 0 = CPU, 1 = DBG; on a tie the port not served last wins
  assign pick_dbg = dbg_req & (~cpu_req | ~last_grant);
  assign win_we   = pick_dbg ? dbg_we : cpu_we;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_data_oe <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req | dbg_req) begin
            grant       <= pick_dbg;
            we_q        <= win_we;
            mem_addr    <= pick_dbg ? dbg_addr : cpu_addr;
            mem_wdata   <= pick_dbg ? dbg_wdata : cpu_wdata;
            cnt         <= 4'(WAIT_CYCLES - 1);
            mem_ce_n    <= 1'b0;
            mem_oe_n    <= win_we;
            mem_we_n    <= ~win_we;
            mem_data_oe <= win_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            if (!we_q) begin
              if (grant) dbg_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            cpu_ack <= ~grant;
            dbg_ack <= grant;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // write data held one cycle past mem_we_n
          mem_data_oe <= 1'b0;
          last_grant  <= grant;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed testbench for slc3_mem_arbiter with a small SRAM model.
// Second instance covers WAIT_CYCLES=1.
module tb_slc3_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_ack, dbg_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_data_oe;

  logic        c1_req;
  logic [15:0] c1_addr;
  logic [15:0] c1_rdata, d1_rdata;
  logic        c1_ack, d1_ack;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ce_n, m1_oe_n, m1_we_n, m1_data_oe;

  logic [15:0] sram [0:255];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sidx(input logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction

  always @(posedge clk)
    if (!mem_ce_n && !mem_we_n && mem_data_oe)
      sram[sidx(mem_addr)] <= mem_wdata;

  assign mem_rdata = (!mem_ce_n && !mem_oe_n) ?
                     sram[sidx(mem_addr)] : 16'h0000;
  assign m1_rdata  = (!m1_ce_n && !m1_oe_n) ?
                     (m1_addr ^ 16'hFFFF) : 16'h0000;

  slc3_mem_arbiter dut (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_rdata(mem_rdata)
  );

  slc3_mem_arbiter #(.WAIT_CYCLES(1)) u1 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(c1_req), .cpu_we(1'b0),
    .cpu_addr(c1_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
    .dbg_req(1'b0), .dbg_we(1'b0),
    .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_rdata(d1_rdata), .dbg_ack(d1_ack),
    .mem_addr(m1_addr), .mem_ce_n(m1_ce_n),
    .mem_oe_n(m1_oe_n), .mem_we_n(m1_we_n),
    .mem_wdata(m1_wdata), .mem_data_oe(m1_data_oe),
    .mem_rdata(m1_rdata)
  );

  task automatic test_reset;
    rst_n    = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h3000;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=1110",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oe});
    end
    checks++;
    if ({cpu_ack, dbg_ack, c1_ack, d1_ack} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_acks got=%b want=0000",
               {cpu_ack, dbg_ack, c1_ack, d1_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_regs got=%h want=0", 
               {mem_addr, mem_wdata, cpu_rdata, dbg_rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_addr} !== {2'b00, 16'h3000}) begin
      failures++;
      $display("FAIL reset_release_start got=%b%b/%h want=00/3000",
               mem_ce_n, mem_oe_n, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL reset_first_ack got=%b/%h want=1/1234",
               cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read;
    int oe_low;
    int ack_at;
    int dbg_seen;
    oe_low   = 0;
    ack_at   = -1;
    dbg_seen = 0;
    cpu_we   = 1'b0;
    cpu_addr = 16'h3000;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      cpu_addr = 16'h0000;
      if (!mem_oe_n && !mem_ce_n) oe_low++;
      if (dbg_ack) dbg_seen++;
      if (cpu_ack) begin
        if (ack_at < 0) ack_at = i;
        cpu_req = 1'b0;
        checks++;
        if (cpu_rdata !== 16'h1234) begin
          failures++;
          $display("FAIL read_data got=%h want=1234", cpu_rdata);
        end
      end
    end
    checks++;
    if (oe_low != 2) begin
      failures++;
      $display("FAIL read_oe_cycles got=%0d want=2", oe_low);
    end
    checks++;
    if (ack_at != 3) begin
      failures++;
      $display("FAIL read_ack_cycle got=%0d want=3", ack_at);
    end
    checks++;
    if (dbg_seen != 0) begin
      failures++;
      $display("FAIL read_dbg_ack got=%0d want=0", dbg_seen);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_dbg_write_cpu_read;
    int we_low;
    int oe_cyc;
    int ack_at;
    int bad_wd;
    we_low    = 0;
    oe_cyc    = 0;
    ack_at    = -1;
    bad_wd    = 0;
    dbg_we    = 1'b1;
    dbg_addr  = 16'h3000;
    dbg_wdata = 16'h0005;
    dbg_req   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      dbg_wdata = 16'hDEAD;
      if (!mem_we_n && !mem_ce_n) we_low++;
      if (mem_data_oe) begin
        oe_cyc++;
        if (mem_wdata !== 16'h0005) bad_wd++;
      end
      if (dbg_ack) begin
        if (ack_at < 0) ack_at = i;
        dbg_req = 1'b0;
      end
    end
    checks++;
    if (we_low != 2) begin
      failures++;
      $display("FAIL write_we_cycles got=%0d want=2", we_low);
    end
    checks++;
    if (oe_cyc != 3 || bad_wd != 0) begin
      failures++;
      $display("FAIL write_data_oe got=%0d bad=%0d want=3 bad=0",
               oe_cyc, bad_wd);
    end
    checks++;
    if (ack_at != 3) begin
      failures++;
      $display("FAIL write_ack_cycle got=%0d want=3", ack_at);
    end
    dbg_we   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 16'h3000;
    cpu_req  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h0005) begin
      failures++;
      $display("FAIL readback got=%b/%h want=1/0005", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h0005 || dbg_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rdata_hold got=%b/%h/%h want=0/0005/0000",
               cpu_ack, cpu_rdata, dbg_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int cpu_at [2];
    int dbg_at [2];
    int nc;
    int nd;
    int bad;
    nc  = 0;
    nd  = 0;
    bad = 0;
    cpu_at = '{-1, -1};
    dbg_at = '{-1, -1};
    sram[sidx(16'h4000)] = 16'hAAAA;
    sram[sidx(16'h4001)] = 16'hBBBB;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    cpu_we   = 1'b0;
    dbg_we   = 1'b0;
    cpu_addr = 16'h4000;
    dbg_addr = 16'h4001;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (cpu_ack && dbg_ack) bad++;
      if (cpu_ack) begin
        if (nc < 2) cpu_at[nc] = i;
        nc++;
        if (cpu_rdata !== 16'hAAAA) bad++;
      end
      if (dbg_ack) begin
        if (nd < 2) dbg_at[nd] = i;
        nd++;
        if (dbg_rdata !== 16'hBBBB) bad++;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    checks++;
    if (nc != 2 || cpu_at[0] != 3 || cpu_at[1] != 11) begin
      failures++;
      $display("FAIL rr_cpu_acks got n=%0d at %0d,%0d want n=2 at 3,11",
               nc, cpu_at[0], cpu_at[1]);
    end
    checks++;
    if (nd != 2 || dbg_at[0] != 7 || dbg_at[1] != 15) begin
      failures++;
      $display("FAIL rr_dbg_acks got n=%0d at %0d,%0d want n=2 at 7,15",
               nd, dbg_at[0], dbg_at[1]);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rr_data got bad=%0d want 0", bad);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    int acks;
    int ack_at;
    acks   = 0;
    ack_at = -1;
    sram[sidx(16'h5000)] = 16'h0000;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h5000;
    cpu_wdata = 16'h00CC;
    cpu_req   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL abort_strobes got=%b want=1110",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oe});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_ce_n, mem_we_n, mem_data_oe, mem_wdata} !== {3'b001, 16'h00CC}) begin
      failures++;
      $display("FAIL abort_restart got=%b%b%b/%h want=001/00cc",
               mem_ce_n, mem_we_n, mem_data_oe, mem_wdata);
    end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        if (ack_at < 0) ack_at = i;
        cpu_req = 1'b0;
      end
    end
    checks++;
    if (acks != 0 || ack_at != 3) begin
      failures++;
      $display("FAIL abort_ack got held=%0d at=%0d want held=0 at=3",
               acks, ack_at);
    end
    checks++;
    if (sram[sidx(16'h5000)] !== 16'h00CC) begin
      failures++;
      $display("FAIL abort_mem got=%h want=00cc", sram[sidx(16'h5000)]);
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_wait1;
    int oe_low;
    int ack_at;
    oe_low  = 0;
    ack_at  = -1;
    c1_addr = 16'h00F0;
    c1_req  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!m1_ce_n && !m1_oe_n) oe_low++;
      if (c1_ack) begin
        if (ack_at < 0) ack_at = i;
        c1_req = 1'b0;
        checks++;
        if (c1_rdata !== 16'hFF0F) begin
          failures++;
          $display("FAIL w1_data got=%h want=ff0f", c1_rdata);
        end
      end
    end
    checks++;
    if (oe_low != 1 || ack_at != 2) begin
      failures++;
      $display("FAIL w1_timing got oe=%0d ack=%0d want oe=1 ack=2",
               oe_low, ack_at);
    end
    checks++;
    if (d1_ack !== 1'b0 || {m1_we_n, m1_data_oe} !== 2'b10) begin
      failures++;
      $display("FAIL w1_idle got=%b%b%b want=010",
               d1_ack, m1_we_n, m1_data_oe);
    end
    c1_req = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    sram[sidx(16'h3000)] = 16'h1234;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = 16'h0000;
    dbg_wdata = 16'h0000;
    c1_req    = 1'b0;
    c1_addr   = 16'h0000;
    @(negedge clk);
    test_reset;
    test_cpu_read;
    test_dbg_write_cpu_read;
    test_back_to_back;
    test_reset_mid_access;
    test_wait1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
